// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS controller:
//   - state_t    : FSM state encodings (4-bit, code 4'hF unused)
//   - OP_*       : opcode field values (IR[31:26]) the controller dispatches on
//   - field codes: alu_op, alu_src_b, pc_source, mem_to_reg, reg_dest
//   - is_known_op: true for every opcode that DECODE can dispatch
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ORIEX  = 4'd11,
        S_IMMWB  = 4'd12,
        S_JUMP   = 4'd13,
        S_JAL    = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] DEST_RT  = 2'b00;
    localparam logic [1:0] DEST_RD  = 2'b01;
    localparam logic [1:0] DEST_R31 = 2'b10;

    function automatic logic is_known_op(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ORI, OP_J, OP_JAL: is_known_op = 1'b1;
            default:                       is_known_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// mips_ctrl_out_decode
// Pure combinational control-word decode: current state plus the (already
// qualified) memory-ready handshake -> datapath control fields.
// Ports:
//   state_cur     in  state_t  current FSM state
//   mem_ready     in  1        memory completes access this cycle
//   pc_write .. ori_ctrl  out  control word fields (see top for meaning)
// Any field not driven by a state stays 0; IDLE and unused codes give all 0.
module mips_ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_t     state_cur,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write_en,
    output logic [1:0] reg_dest,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       ori_ctrl
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write_en  = 1'b0;
        reg_dest      = DEST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        ori_ctrl      = 1'b0;

        case (state_cur)
            S_FETCH: begin
                // IR and PC+4 commit only on the cycle the read data is valid
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // precompute branch target into ALUOut
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg   = M2R_MDR;
                reg_write_en = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_dest     = DEST_RD;
                reg_write_en = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_source     = PCSRC_ALUOUT;
                pc_write_cond = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OR;
                ori_ctrl  = 1'b1;
            end
            S_IMMWB: begin
                reg_write_en = 1'b1;
            end
            S_JUMP: begin
                pc_source = PCSRC_JUMP;
                pc_write  = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pc_source    = PCSRC_JUMP;
                pc_write     = 1'b1;
                reg_dest     = DEST_R31;
                mem_to_reg   = M2R_PC;
                reg_write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore FSM sequencing a multi-cycle MIPS datapath with one shared memory.
// Holds the state register and next-state logic; the control word is decoded
// combinationally from state by mips_ctrl_out_decode.
// Parameters:
//   MEM_WAIT_EN  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: ready assumed
//   STATE_W      width of the debug state output
// Ports:
//   clk, reset (async, active-high), opcode (IR[31:26]), mem_ready
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   reg_write_en, reg_dest, mem_to_reg, alu_src_a, alu_src_b, alu_op,
//   pc_source, ori_ctrl : control word
//   illegal_op : one-cycle pulse in DECODE on an unknown opcode
//   state      : current state code
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write_en,
    output logic [1:0]         reg_dest,
    output logic [1:0]         mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               ori_ctrl,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    logic   ready;

    assign ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_q <= S_FETCH;
                S_FETCH:  if (ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_ORI:       state_q <= S_ORIEX;
                        OP_J:         state_q <= S_JUMP;
                        OP_JAL:       state_q <= S_JAL;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    if (opcode == OP_LW)      state_q <= S_MEMRD;
                    else if (opcode == OP_SW) state_q <= S_MEMWR;
                    else                      state_q <= S_FETCH;
                end
                S_MEMRD:  if (ready) state_q <= S_MEMWB;
                S_MEMWR:  if (ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_IMMWB;
                S_ORIEX:  state_q <= S_IMMWB;
                S_MEMWB, S_ALUWB, S_IMMWB,
                S_BRANCH, S_JUMP, S_JAL: state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign illegal_op = (state_q == S_DECODE) && !is_known_op(opcode);
    assign state      = STATE_W'(state_q);

    mips_ctrl_out_decode u_out_decode (
        .state_cur     (state_q),
        .mem_ready     (ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write_en  (reg_write_en),
        .reg_dest      (reg_dest),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ori_ctrl      (ori_ctrl)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Directed bench for multicycle_control: expected per-cycle state and control
// word are queued as each instruction's stimulus is laid out, then popped and
// compared one cycle at a time while the inputs are driven.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write_en, alu_src_a, ori_ctrl, illegal_op;
    logic [1:0] reg_dest, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write_en  (reg_write_en),
        .reg_dest      (reg_dest),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .ori_ctrl      (ori_ctrl),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    // {pcw, pcwc, iord, mrd, mwr, irw, rwe, rdst[2], m2r[2], srca, srcb[2], aluop[2], pcsrc[2], ori, ill}
    logic [19:0] obs_ctl;
    assign obs_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      reg_write_en, reg_dest, mem_to_reg, alu_src_a, alu_src_b,
                      alu_op, pc_source, ori_ctrl, illegal_op};

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] ctl;
    } exp_t;

    exp_t sb[$];

    // Expected control word for a state, written field by field from the
    // datapath's control table.
    function automatic logic [19:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic ill);
        logic pcw, pcwc, iord, mrd, mwr, irw, rwe, srca, ori;
        logic [1:0] rdst, m2r, srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mrd, mwr, irw, rwe, srca, ori} = '0;
        {rdst, m2r, srcb, aluop, pcsrc} = '0;
        if (st == 4'd1)  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
        if (st == 4'd2)  begin srcb = 2'b11; end
        if (st == 4'd3)  begin srca = 1; srcb = 2'b10; end
        if (st == 4'd4)  begin iord = 1; mrd = 1; end
        if (st == 4'd5)  begin m2r = 2'b01; rwe = 1; end
        if (st == 4'd6)  begin iord = 1; mwr = 1; end
        if (st == 4'd7)  begin srca = 1; aluop = 2'b10; end
        if (st == 4'd8)  begin rdst = 2'b01; rwe = 1; end
        if (st == 4'd9)  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcwc = 1; end
        if (st == 4'd10) begin srca = 1; srcb = 2'b10; end
        if (st == 4'd11) begin srca = 1; srcb = 2'b10; aluop = 2'b11; ori = 1; end
        if (st == 4'd12) begin rwe = 1; end
        if (st == 4'd13) begin pcsrc = 2'b10; pcw = 1; end
        if (st == 4'd14) begin pcsrc = 2'b10; pcw = 1; rdst = 2'b10; m2r = 2'b10; rwe = 1; end
        return {pcw, pcwc, iord, mrd, mwr, irw, rwe, rdst, m2r, srca, srcb, aluop, pcsrc, ori, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic [5:0] op, input logic rdy,
                        input logic ill = 1'b0);
        exp_t e;
        e.op  = op;
        e.rdy = rdy;
        e.st  = st;
        e.ctl = exp_ctl(st, rdy, ill);
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered just after a falling edge; each entry drives one cycle.
    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode    = e.op;
            mem_ready = e.rdy;
            #1;
            check($sformatf("state_c%0d", cyc), {28'd0, state}, {28'd0, e.st});
            check($sformatf("ctl_c%0d", cyc), {12'd0, obs_ctl}, {12'd0, e.ctl});
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset     = 1'b1;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("reset_state", {28'd0, state}, 32'd0);
        check("reset_ctl", {12'd0, obs_ctl}, 32'd0);
        #1 reset = 1'b0;

        // R-type, zero wait; mem_ready ignored outside handshake states
        push(4'd0, 6'b000000, 1'b0);
        push(4'd1, 6'b000000, 1'b1);
        push(4'd2, 6'b000000, 1'b0);
        push(4'd7, 6'b000000, 1'b1);
        push(4'd8, 6'b000000, 1'b0);
        // lw, two wait cycles in MEMRD -> 7 cycles
        push(4'd1, 6'b100011, 1'b1);
        push(4'd2, 6'b100011, 1'b1);
        push(4'd3, 6'b100011, 1'b1);
        push(4'd4, 6'b100011, 1'b0);
        push(4'd4, 6'b100011, 1'b0);
        push(4'd4, 6'b100011, 1'b1);
        push(4'd5, 6'b100011, 1'b1);
        // sw, three wait cycles in FETCH
        push(4'd1, 6'b101011, 1'b0);
        push(4'd1, 6'b101011, 1'b0);
        push(4'd1, 6'b101011, 1'b0);
        push(4'd1, 6'b101011, 1'b1);
        push(4'd2, 6'b101011, 1'b0);
        push(4'd3, 6'b101011, 1'b0);
        push(4'd6, 6'b101011, 1'b1);
        // jal
        push(4'd1, 6'b000011, 1'b1);
        push(4'd2, 6'b000011, 1'b0);
        push(4'd14, 6'b000011, 1'b0);
        // illegal opcode: one-cycle pulse, back to FETCH
        push(4'd1, 6'b111111, 1'b1);
        push(4'd2, 6'b111111, 1'b1, 1'b1);
        // beq
        push(4'd1, 6'b000100, 1'b1);
        push(4'd2, 6'b000100, 1'b0);
        push(4'd9, 6'b000100, 1'b1);
        // j
        push(4'd1, 6'b000010, 1'b1);
        push(4'd2, 6'b000010, 1'b0);
        push(4'd13, 6'b000010, 1'b0);
        // addi
        push(4'd1, 6'b001000, 1'b1);
        push(4'd2, 6'b001000, 1'b0);
        push(4'd10, 6'b001000, 1'b1);
        push(4'd12, 6'b001000, 1'b0);
        // ori
        push(4'd1, 6'b001101, 1'b1);
        push(4'd2, 6'b001101, 1'b0);
        push(4'd11, 6'b001101, 1'b0);
        push(4'd12, 6'b001101, 1'b1);
        // sw up to MEMWR, then reset mid-access
        push(4'd1, 6'b101011, 1'b1);
        push(4'd2, 6'b101011, 1'b0);
        push(4'd3, 6'b101011, 1'b0);
        drain();

        opcode    = 6'b101011;
        mem_ready = 1'b0;
        #1;
        check("memwr_state", {28'd0, state}, 32'd6);
        check("memwr_strobe", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_strobe", {31'd0, mem_write}, 32'd0);
        check("abort_state", {28'd0, state}, 32'd0);
        check("abort_ctl", {12'd0, obs_ctl}, 32'd0);
        #1 reset = 1'b0;
        push(4'd0, 6'b000000, 1'b1);
        push(4'd1, 6'b000000, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
